// File: rtl/seq_shifter.sv
// seq_shifter: multi-cycle SLL/SRL/SRA/ROTL unit, up to STEP bits per cycle.
// Start/Busy/Done handshake; Out holds the last completed result.
module seq_shifter #(
  parameter  int N       = 32,
  parameter  int STEP    = 4,
  localparam int SHAMT_W = $clog2(N)
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic               Start,
  input  logic [N-1:0]       In,
  input  logic [SHAMT_W-1:0] Shamt,
  input  logic [1:0]         Mode,
  output logic               Busy,
  output logic               Done,
  output logic [N-1:0]       Out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [1:0] M_SLL = 2'd0;
  localparam logic [1:0] M_SRL = 2'd1;
  localparam logic [1:0] M_SRA = 2'd2;

  localparam logic [SHAMT_W:0] STEP_K = (SHAMT_W+1)'(STEP);

  state_e             state_q, state_d;
  logic [N-1:0]       w_q, w_d;
  logic [N-1:0]       out_q, out_d;
  logic [SHAMT_W-1:0] r_q, r_d;
  logic [1:0]         m_q, m_d;

  logic [SHAMT_W:0]   k;
  logic [N-1:0]       w_sh;
  logic [2*N-1:0]     rot;

  // One step of the datapath: shift W by min(R, STEP) in the captured mode
  always_comb begin
    k   = ({1'b0, r_q} > STEP_K) ? STEP_K : {1'b0, r_q};
    rot = {w_q, w_q} << k;
    unique case (m_q)
      M_SLL:   w_sh = w_q << k;
      M_SRL:   w_sh = w_q >> k;
      M_SRA:   w_sh = $signed(w_q) >>> k;
      default: w_sh = rot[2*N-1:N];
    endcase
  end

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    r_d     = r_q;
    m_d     = m_q;
    out_d   = out_q;
    unique case (state_q)
      IDLE: begin
        if (Start) begin
          w_d = In;
          r_d = Shamt;
          m_d = Mode;
          if (Shamt == '0) begin
            state_d = DONE;
            out_d   = In;
          end else begin
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        w_d = w_sh;
        r_d = r_q - k[SHAMT_W-1:0];
        if ({1'b0, r_q} <= STEP_K) begin
          state_d = DONE;
          out_d   = w_sh;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      w_q     <= '0;
      r_q     <= '0;
      m_q     <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      r_q     <= r_d;
      m_q     <= m_d;
      out_q   <= out_d;
    end
  end

  assign Busy = (state_q != IDLE);
  assign Done = (state_q == DONE);
  assign Out  = out_q;

endmodule

// File: tb/tb_seq_shifter.sv
// Bench for seq_shifter: three instances (STEP=4, 1, 32) checked
// against an arithmetic reference for result and latency.
module tb_seq_shifter;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic [2:0]  st;
  logic [31:0] a_in;
  logic [4:0]  sh_in;
  logic [1:0]  md_in;
  logic [2:0]  busy, done;
  logic [31:0] out [3];

  int          n_chk = 0;
  int          n_fail = 0;
  int          obs_lat [3];
  int          obs_busy [3];
  logic [31:0] obs_out [3];
  int          steps [3] = '{4, 1, 32};

  always #5 Clk = ~Clk;

  seq_shifter #(.N(32), .STEP(4)) u_s4 (
    .Clk(Clk), .Rst_n(Rst_n), .Start(st[0]), .In(a_in),
    .Shamt(sh_in), .Mode(md_in), .Busy(busy[0]),
    .Done(done[0]), .Out(out[0])
  );
  seq_shifter #(.N(32), .STEP(1)) u_s1 (
    .Clk(Clk), .Rst_n(Rst_n), .Start(st[1]), .In(a_in),
    .Shamt(sh_in), .Mode(md_in), .Busy(busy[1]),
    .Done(done[1]), .Out(out[1])
  );
  seq_shifter #(.N(32), .STEP(32)) u_s32 (
    .Clk(Clk), .Rst_n(Rst_n), .Start(st[2]), .In(a_in),
    .Shamt(sh_in), .Mode(md_in), .Busy(busy[2]),
    .Done(done[2]), .Out(out[2])
  );

  function automatic logic [31:0] ref_shift(
    input logic [31:0] a, input int sh, input logic [1:0] md);
    case (md)
      2'd0:    return a << sh;
      2'd1:    return a >> sh;
      2'd2:    return $signed(a) >>> sh;
      default: return (sh == 0) ? a : ((a << sh) | (a >> (32 - sh)));
    endcase
  endfunction

  function automatic int ref_lat(input int sh, input int step);
    return (sh + step - 1) / step + 1;
  endfunction

  // Launch one op on the masked instances, record latency/result/busy time
  task automatic run_op(input logic [31:0] a, input int sh,
                        input logic [1:0] md, input logic [2:0] msk);
    a_in  = a;
    sh_in = 5'(sh);
    md_in = md;
    st    = msk;
    @(posedge Clk); #1;
    st = '0;
    for (int i = 0; i < 3; i++) begin
      obs_lat[i]  = -1;
      obs_busy[i] = 0;
      obs_out[i]  = 'x;
    end
    for (int c = 1; c <= 40; c++) begin
      bit pend = 0;
      for (int i = 0; i < 3; i++) begin
        if (msk[i]) begin
          if (busy[i]) obs_busy[i]++;
          if (obs_lat[i] < 0 && done[i]) begin
            obs_lat[i] = c;
            obs_out[i] = out[i];
          end
          if (obs_lat[i] < 0) pend = 1;
        end
      end
      @(posedge Clk); #1;
      if (!pend) break;
    end
  endtask

  task automatic test_reset;
    Rst_n = 1'b0; st = '0; a_in = '0; sh_in = '0; md_in = '0;
    repeat (2) @(posedge Clk);
    #1;
    n_chk++;
    if (busy !== 3'b000) begin
      n_fail++; $display("FAIL reset_busy got=%b want=000", busy);
    end
    n_chk++;
    if (done !== 3'b000) begin
      n_fail++; $display("FAIL reset_done got=%b want=000", done);
    end
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (out[i] !== 32'h0) begin
        n_fail++; $display("FAIL reset_out[%0d] got=%h want=0", i, out[i]);
      end
    end
    Rst_n = 1'b1;
    @(posedge Clk); #1;
  endtask

  task automatic test_directed;
    logic [31:0] va [5] = '{32'h1, 32'h8000_0000, 32'h8000_0000,
                            32'h8000_0001, 32'h1234_5678};
    int          vs [5] = '{2, 31, 31, 1, 0};
    logic [1:0]  vm [5] = '{2'd0, 2'd2, 2'd1, 2'd3, 2'd3};
    logic [31:0] vo [5] = '{32'h4, 32'hFFFF_FFFF, 32'h1,
                            32'h3, 32'h1234_5678};
    int          vl [5] = '{2, 9, 9, 2, 1};
    for (int t = 0; t < 5; t++) begin
      run_op(va[t], vs[t], vm[t], 3'b001);
      n_chk++;
      if (obs_out[0] !== vo[t]) begin
        n_fail++;
        $display("FAIL dir%0d_out got=%h want=%h", t, obs_out[0], vo[t]);
      end
      n_chk++;
      if (obs_lat[0] != vl[t]) begin
        n_fail++;
        $display("FAIL dir%0d_lat got=%0d want=%0d", t, obs_lat[0], vl[t]);
      end
      n_chk++;
      if (obs_busy[0] != vl[t]) begin
        n_fail++;
        $display("FAIL dir%0d_busy got=%0d want=%0d", t, obs_busy[0], vl[t]);
      end
    end
  endtask

  task automatic test_start_ignored;
    int c;
    a_in = 32'h1; sh_in = 5'd8; md_in = 2'd0; st = 3'b001;
    @(posedge Clk); #1;
    a_in = 32'hFFFF_FFFF;
    c = 1;
    while (!done[0] && c < 20) begin
      @(posedge Clk); #1; c++;
    end
    n_chk++;
    if (c != 3) begin
      n_fail++; $display("FAIL ign_lat got=%0d want=3", c);
    end
    n_chk++;
    if (out[0] !== 32'h100) begin
      n_fail++; $display("FAIL ign_out got=%h want=00000100", out[0]);
    end
    @(posedge Clk); #1;
    n_chk++;
    if (busy[0] !== 1'b0 || out[0] !== 32'h100) begin
      n_fail++;
      $display("FAIL ign_idle got busy=%b out=%h want busy=0 out=00000100",
               busy[0], out[0]);
    end
    @(posedge Clk); #1;
    st = '0;
    n_chk++;
    if (busy[0] !== 1'b1) begin
      n_fail++; $display("FAIL b2b_accept got=%b want=1", busy[0]);
    end
    c = 0;
    while (!done[0] && c < 20) begin
      @(posedge Clk); #1; c++;
    end
    n_chk++;
    if (out[0] !== 32'hFFFF_FF00) begin
      n_fail++; $display("FAIL b2b_out got=%h want=ffffff00", out[0]);
    end
    @(posedge Clk); #1;
  endtask

  task automatic test_reset_midop;
    int nd = 0;
    a_in = $urandom | 32'h1; sh_in = 5'd20; md_in = 2'd0; st = 3'b001;
    @(posedge Clk); #1;
    st = '0;
    repeat (2) @(posedge Clk);
    #1;
    Rst_n = 1'b0;
    @(posedge Clk); #1;
    Rst_n = 1'b1;
    n_chk++;
    if (busy[0] !== 1'b0 || done[0] !== 1'b0 || out[0] !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_mid got busy=%b done=%b out=%h want 0 0 0",
               busy[0], done[0], out[0]);
    end
    for (int c = 0; c < 12; c++) begin
      if (done[0] || busy[0]) nd++;
      @(posedge Clk); #1;
    end
    n_chk++;
    if (nd != 0) begin
      n_fail++; $display("FAIL rst_discard got=%0d activity want=0", nd);
    end
    Rst_n = 1'b0; st = 3'b111; a_in = 32'hA5A5_A5A5; sh_in = 5'd5;
    @(posedge Clk); #1;
    Rst_n = 1'b1; st = '0;
    n_chk++;
    if (busy !== 3'b000) begin
      n_fail++; $display("FAIL rst_start got=%b want=000", busy);
    end
    @(posedge Clk); #1;
    n_chk++;
    if (busy !== 3'b000 || done !== 3'b000) begin
      n_fail++;
      $display("FAIL rst_start2 got busy=%b done=%b want 000 000", busy, done);
    end
  endtask

  task automatic test_sweep;
    int el [3] = '{4, 11, 2};
    run_op(32'hFFFF_FFFF, 10, 2'd1, 3'b111);
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (obs_out[i] !== 32'h003F_FFFF) begin
        n_fail++;
        $display("FAIL sweep%0d_out got=%h want=003fffff", steps[i], obs_out[i]);
      end
      n_chk++;
      if (obs_lat[i] != el[i]) begin
        n_fail++;
        $display("FAIL sweep%0d_lat got=%0d want=%0d", steps[i], obs_lat[i], el[i]);
      end
    end
  endtask

  task automatic test_random;
    logic [31:0] a, e;
    int          sh;
    logic [1:0]  md;
    for (int v = 0; v < 1500; v++) begin
      a  = $urandom;
      sh = $urandom_range(0, 31);
      md = 2'($urandom_range(0, 3));
      e  = ref_shift(a, sh, md);
      run_op(a, sh, md, 3'b111);
      for (int i = 0; i < 3; i++) begin
        n_chk++;
        if (obs_out[i] !== e || out[i] !== e) begin
          n_fail++;
          $display("FAIL rnd_out s%0d a=%h sh=%0d m=%0d got=%h held=%h want=%h",
                   steps[i], a, sh, md, obs_out[i], out[i], e);
        end
        n_chk++;
        if (obs_lat[i] != ref_lat(sh, steps[i])) begin
          n_fail++;
          $display("FAIL rnd_lat s%0d sh=%0d got=%0d want=%0d",
                   steps[i], sh, obs_lat[i], ref_lat(sh, steps[i]));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_start_ignored();
    test_reset_midop();
    test_sweep();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
